// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate unit.
package imm_pkg;

    // Widest supported datapath; buffered entries are sized for it.
    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [2:0] {
        ImmNone  = 3'd0,
        ImmI     = 3'd1,
        ImmS     = 3'd2,
        ImmB     = 3'd3,
        ImmU     = 3'd4,
        ImmJ     = 3'd5,
        ImmShamt = 3'd6,
        ImmZimm  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;

    // One buffered decode result; pc/imm/target are zero-extended when XLEN < XLEN_MAX.
    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic [XLEN_MAX-1:0] target;
        logic                unknown;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate decode stage.
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_imm_type;
    logic [XLEN-1:0] out_target;
    logic            out_unknown;

    // Surrounding pipeline side
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_target,
               out_unknown
    );

    // Decode stage side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_target,
               out_unknown
    );

endinterface

// File: rtl/imm_format_unit.sv
// Combinational immediate classifier/extractor driven purely by the opcode and funct3.
module imm_format_unit
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_imm_type,
    output logic            o_unknown
);

    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm32;
    logic        w_sext;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];

    // Pick the immediate format from the opcode (and funct3 for OP-IMM/SYSTEM)
    always_comb begin
        o_imm_type = ImmNone;
        o_unknown  = 1'b0;
        unique case (w_opcode)
            OpcLoad, OpcJalr: o_imm_type = ImmI;
            OpcOpImm: begin
                o_imm_type = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? ImmShamt : ImmI;
            end
            OpcStore:         o_imm_type = ImmS;
            OpcBranch:        o_imm_type = ImmB;
            OpcLui, OpcAuipc: o_imm_type = ImmU;
            OpcJal:           o_imm_type = ImmJ;
            OpcSystem: begin
                if (w_funct3[2]) begin
                    o_imm_type = ImmZimm;
                end else if (w_funct3 != 3'b000) begin
                    o_imm_type = ImmI;
                end
            end
            OpcOp, OpcMiscMem: o_imm_type = ImmNone;
            default:           o_unknown  = 1'b1;
        endcase
    end

    // Build a 32-bit immediate; w_sext marks formats that keep extending past bit 31
    always_comb begin
        w_imm32 = '0;
        w_sext  = 1'b0;
        unique case (o_imm_type)
            ImmI: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                w_sext  = 1'b1;
            end
            ImmS: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_sext  = 1'b1;
            end
            ImmB: begin
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
                w_sext  = 1'b1;
            end
            ImmJ: begin
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
                w_sext  = 1'b1;
            end
            ImmU: begin
                w_imm32 = {i_instr[31:12], 12'b0};
                w_sext  = 1'b1;
            end
            // instr[30] (SRAI flag) lies above the shamt field and is never picked up
            ImmShamt: w_imm32 = 32'(i_instr[20 +: SHAMT_W]);
            ImmZimm:  w_imm32 = 32'(i_instr[19:15]);
            default:  w_imm32 = '0;
        endcase
    end

    assign o_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate unit: decode + pc+imm before a 2-entry registered skid buffer.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    imm_decode_stage_if.slave bus
);

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    imm_type_e       w_imm_type;
    logic            w_unknown;
    imm_entry_t      w_entry;
    logic            w_in_fire;
    logic            w_out_fire;

    imm_entry_t      r_main;
    imm_entry_t      r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;

    imm_format_unit #(
        .XLEN (XLEN)
    ) u_format (
        .i_instr    (bus.in_instr),
        .o_imm      (w_imm),
        .o_imm_type (w_imm_type),
        .o_unknown  (w_unknown)
    );

    assign w_target   = bus.in_pc + w_imm;
    assign w_in_fire  = bus.in_valid & ~r_skid_valid;
    assign w_out_fire = r_main_valid & bus.out_ready;

    // Pack the fully decoded instruction so only registers sit on the output path
    always_comb begin
        w_entry          = '0;
        w_entry.instr    = bus.in_instr;
        w_entry.pc       = XLEN_MAX'(bus.in_pc);
        w_entry.imm      = XLEN_MAX'(w_imm);
        w_entry.imm_type = w_imm_type;
        w_entry.target   = XLEN_MAX'(w_target);
        w_entry.unknown  = w_unknown;
    end

    // Main entry drives the outputs; skid catches one extra entry while main is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_out_fire) begin
            if (r_skid_valid) begin
                // in_ready was low, so no new input can arrive on this edge
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main <= w_entry;
                end
            end
        end else if (w_in_fire) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready     = ~r_skid_valid;
    assign bus.out_valid    = r_main_valid;
    assign bus.out_instr    = r_main.instr;
    assign bus.out_pc       = r_main.pc[XLEN-1:0];
    assign bus.out_imm      = r_main.imm[XLEN-1:0];
    assign bus.out_imm_type = r_main.imm_type;
    assign bus.out_target   = r_main.target[XLEN-1:0];
    assign bus.out_unknown  = r_main.unknown;

    // Upper entry bits are always zero on a narrow datapath and are never presented
    if (XLEN < XLEN_MAX) begin : gen_narrow
        logic w_unused_hi;
        assign w_unused_hi = ^{r_main.pc[XLEN_MAX-1:XLEN], r_main.imm[XLEN_MAX-1:XLEN],
                               r_main.target[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-stage immediate unit for the 5-stage core. Classifies the immediate format directly from the opcode, with no external select.
- Produces an XLEN-wide immediate for all formats, including shift-amount and CSR zimm, and precomputes pc+imm for the branch/jump target.
- Registered with a valid/ready handshake, a 2-entry skid buffer and flush. Sits between the IF/ID register and the ID/EX register.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount field width; derived, do not override.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  squash all buffered entries (branch mispredict/trap)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  upstream may transfer
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction passed through
- out_pc  out  XLEN  PC passed through
- out_imm  out  XLEN  decoded immediate
- out_imm_type  out  3  imm_type_e of the entry
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_unknown  out  1  opcode not in RV32I/RV64I base set

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, in_ready=1, skid empty. out_imm, out_pc, out_target and out_instr are 0; out_imm_type=NONE; out_unknown=0.
- Format classification from instr[6:0] and funct3:
  - LOAD, JALR, OP-IMM (funct3 ∉ {001,101}) → I
  - OP-IMM funct3 001/101 → SHAMT
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
  - SYSTEM funct3[2]=1 → ZIMM; SYSTEM funct3 001/010/011 → I; SYSTEM funct3 000 → NONE
  - OP, MISC-MEM → NONE
  - any other opcode → NONE with out_unknown=1
- Extension rules:
  - I/S/B/J: sign-extended from instr[31] to XLEN.
  - U: {instr[31:12],12'b0}, then sign-extended from bit 31 to XLEN when XLEN=64.
  - SHAMT: zero-extended instr[20+SHAMT_W-1:20]; instr[30] (SRAI flag) is excluded.
  - ZIMM: zero-extended instr[19:15].
  - NONE: 0.
- Target: out_target = out_pc + out_imm for every type, truncated to XLEN (wrap-around, no overflow flag).
- Handshake: a transfer occurs when valid&ready on the same edge. Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N, provided the main register was empty or draining.
- in_ready is registered: 1 exactly when the skid entry is empty.
  - If out_ready=0 while the main register is full and an input is accepted, the input goes to skid and in_ready falls next cycle.
  - When the main register drains, skid moves into main on that edge and in_ready returns to 1.
- Outputs are stable while out_valid=1 and out_ready=0. Order is strictly FIFO; no drops, no duplicates.
- flush=1 at an edge:
  - Both entries are invalidated; out_valid=0 and in_ready=1 next cycle.
  - An input presented that cycle is dropped even if in_valid&in_ready.
  - An output handshake that cycle still counts as consumed.
- Flush and reset in the same cycle: reset dominates (same result).
- Reset mid-stream discards everything; no partial state survives.
- All decode is done before the register (decode→register), so output timing is register-only.

Decomposition:
- Package imm_pkg:
  - imm_type_e enum (NONE=0, I, S, B, U, J, SHAMT, ZIMM).
  - Opcode localparams: LOAD 0000011, OP_IMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111, SYSTEM 1110011, MISC_MEM 0001111.
  - A packed struct for the buffered entry (instr, pc, imm, type, target, unknown).
- One combinational sub-module, imm_format_unit (param XLEN): instr in → imm, type, unknown out. imm_decode_stage owns the adder and the 2-entry skid buffer.

Test Plan:
- XLEN=32, out_ready=1, in_instr=0xFFF00093 (addi x1,x0,-1), pc=0x100 → one cycle later out_imm=0xFFFFFFFF, type=I, out_target=0x000000FF.
- in_instr=0xFE000EE3 (beq x0,x0,-4), pc=0x100 → out_imm=0xFFFFFFFC, type=B, out_target=0x000000FC. With in_instr=0x0200006F (jal +0x20), pc=0xFFFFFFF0 → out_imm=0x20, type=J, out_target=0x00000010 (wrap).
- in_instr=0x4030D093 (srai x1,x1,3) → type=SHAMT, out_imm=0x3 (not 0x403). in_instr=0x0000F073 (csrrci zimm=1) → type=ZIMM, out_imm=0x1. in_instr=0x0000007F → out_unknown=1, out_imm=0.
- Backpressure: out_ready=0, push A, B, C back-to-back → A, B accepted, in_ready=0 from the cycle after B and C held upstream. Then out_ready=1 → A, B, C emerge in order, one per cycle, none lost.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed input never appears. Repeat with rst_n=0 mid-stream → same empty state and all outputs 0.
- XLEN=64: in_instr=0x800000B7 (lui x1,0x80000) → out_imm=0xFFFFFFFF80000000. slli x1,x1,63 (0x03F09093) → out_imm=0x3F.
